// File: rtl/mem_access_unit.sv
// Memory stage: EX/MEM -> data-memory req/gnt/rvalid port -> MEM/WB register.
// Optional build macro MISALIGN_TRAP_EN turns misaligned half/word accesses into a flagged no-op.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              valid_in,
  input  logic              mem_in,
  input  logic              mem_write_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_unsigned_in,
  input  logic              write_back_in,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   alu_in_2_in,
  input  logic [4:0]        reg_rd_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid_out,
  output logic              write_back_out,
  output logic [4:0]        reg_rd_out,
  output logic [XLEN-1:0]   wb_data_out,
  output logic              misalign_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_addr;
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic            r_wb;
  logic [4:0]      r_rd;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;

  logic            r_wb_valid;
  logic            r_wb_we;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_misalign;

  logic [1:0]      w_a;
  logic [3:0]      w_be_in;
  logic [XLEN-1:0] w_wdata_in;
  logic            w_misalign_in;
  logic            w_req;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  assign w_a = alu_result_in[1:0];

  // Lane steering; misaligned half/word silently fall back to the aligned lanes.
  always_comb begin
    w_be_in    = '0;
    w_wdata_in = '0;
    case (mem_size_in)
      2'b00: begin
        w_be_in    = 4'b0001 << w_a;
        w_wdata_in = {4{alu_in_2_in[7:0]}};
      end
      2'b01: begin
        w_be_in    = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata_in = {2{alu_in_2_in[15:0]}};
      end
      default: begin
        w_be_in    = 4'b1111;
        w_wdata_in = alu_in_2_in;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_misalign_in = ((mem_size_in == 2'b01) && w_a[0]) ||
                         (mem_size_in[1] && (w_a != 2'b00));
`else
  assign w_misalign_in = 1'b0;
`endif

  always_comb begin
    w_byte = dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_load = '0;
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  // DONE behaves as IDLE for acceptance, so back-to-back instructions need no bubble.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_wb       <= 1'b0;
      r_rd       <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (valid_in) begin
            if (!mem_in) begin
              r_wb_valid <= 1'b1;
              r_wb_we    <= write_back_in;
              r_wb_rd    <= reg_rd_in;
              r_wb_data  <= alu_result_in;
            end else begin
              r_addr     <= alu_result_in;
              r_we       <= mem_write_in;
              r_size     <= mem_size_in;
              r_unsigned <= mem_unsigned_in;
              r_wb       <= write_back_in;
              r_rd       <= reg_rd_in;
              r_be       <= w_be_in;
              r_wdata    <= w_wdata_in;
              if (w_misalign_in) begin
                r_state    <= S_DONE;
                r_wb_valid <= 1'b1;
                r_wb_we    <= 1'b0;
                r_wb_rd    <= reg_rd_in;
                r_wb_data  <= alu_result_in;
                r_misalign <= 1'b1;
              end else begin
                r_state <= S_REQ;
              end
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            if (r_we) begin
              r_state    <= S_DONE;
              r_wb_valid <= 1'b1;
              r_wb_we    <= 1'b0;
              r_wb_rd    <= r_rd;
              r_wb_data  <= '0;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            r_state    <= S_DONE;
            r_wb_valid <= 1'b1;
            r_wb_we    <= r_wb;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_req      = (r_state == S_REQ);
  assign stall_out  = (r_state == S_REQ) || (r_state == S_WAIT);
  assign dmem_req   = w_req;
  assign dmem_we    = w_req & r_we;
  assign dmem_addr  = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = w_req ? r_be : '0;
  assign dmem_wdata = w_req ? r_wdata : '0;

  assign wb_valid_out   = r_wb_valid;
  assign write_back_out = r_wb_we;
  assign reg_rd_out     = r_wb_rd;
  assign wb_data_out    = r_wb_data;
  assign misalign_out   = r_misalign;

endmodule
